// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one memory port between an instruction-fetch requester and a data
//   (load/store) requester. A three-state FSM (IDLE, BUSY_I, BUSY_D) grants
//   one requester at a time. The winner's address/we/wdata are latched at the
//   grant edge and drive the memory port for the whole access. Completion is
//   signalled by a one-cycle ack and the read data is held afterwards. An
//   8-bit wait counter aborts an access that sees no mem_ready within TMO
//   busy cycles and raises a sticky timeout flag.
//
// Configuration:
//   MEM_ARBITER_RR_EN - when defined, a tie in IDLE goes to the requester not
//                       served last (flag resets to "data", so the first tie
//                       goes to fetch). When undefined, data beats fetch.
//
// Parameters:
//   n   - address/data width of both requesters and the memory port
//   TMO - busy cycles without mem_ready before the access is timed out
//
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   if_req/if_addr        - fetch request (level) and address
//   if_rdata/if_ack       - fetched word (held) and one-cycle completion
//   d_req/d_we/d_addr/d_wdata - data request (level), store flag, addr, data
//   d_rdata/d_ack         - load data (held) and one-cycle completion
//   mem_req/mem_we/mem_addr/mem_wdata - memory access strobe and command
//   mem_rdata/mem_ready   - memory read data and completion
//   stall                 - a requester is waiting for its ack
//   timeout               - sticky flag, set when an access timed out
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned n   = 32,
    parameter int unsigned TMO = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_req,
    input  logic [n-1:0] if_addr,
    output logic [n-1:0] if_rdata,
    output logic         if_ack,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [n-1:0] d_addr,
    input  logic [n-1:0] d_wdata,
    output logic [n-1:0] d_rdata,
    output logic         d_ack,
    output logic         mem_req,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic         stall,
    output logic         timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [7:0] TMO_C = 8'(TMO);

    state_t       state_q, state_d;
    logic [n-1:0] addr_q, addr_d;
    logic         we_q, we_d;
    logic [n-1:0] wdata_q, wdata_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [n-1:0] if_rdata_q, if_rdata_d;
    logic [n-1:0] d_rdata_q, d_rdata_d;
    logic         if_ack_q, if_ack_d;
    logic         d_ack_q, d_ack_d;
    logic         timeout_q, timeout_d;
`ifdef MEM_ARBITER_RR_EN
    logic         last_d_q, last_d_d;
`endif

    logic         if_elig;
    logic         d_elig;
    logic         grant_i;
    logic         grant_d;
    logic [7:0]   cnt_inc;

    // A requester whose ack is showing this cycle still has req high; it must
    // not be granted again for the same request.
    always_comb begin
        if_elig = if_req & ~if_ack_q;
        d_elig  = d_req  & ~d_ack_q;
`ifdef MEM_ARBITER_RR_EN
        // Tie goes to fetch when data was served last.
        grant_d = d_elig & (~if_elig | ~last_d_q);
`else
        grant_d = d_elig;
`endif
        grant_i = if_elig & ~grant_d;
    end

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        timeout_d  = timeout_q;
`ifdef MEM_ARBITER_RR_EN
        last_d_d   = last_d_q;
`endif

        case (state_q)
            IDLE: begin
                // mem_ready is deliberately ignored here.
                if (grant_d) begin
                    state_d = BUSY_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    cnt_d   = 8'd0;
`ifdef MEM_ARBITER_RR_EN
                    last_d_d = 1'b1;
`endif
                end else if (grant_i) begin
                    state_d = BUSY_I;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    cnt_d   = 8'd0;
`ifdef MEM_ARBITER_RR_EN
                    last_d_d = 1'b0;
`endif
                end
            end

            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    if (state_q == BUSY_D) begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    // The TMO-th busy cycle without mem_ready ends the access
                    // with zero data and a normal ack so the requester unblocks.
                    if (cnt_inc >= TMO_C) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                        if (state_q == BUSY_D) begin
                            d_rdata_d = '0;
                            d_ack_d   = 1'b1;
                        end else begin
                            if_rdata_d = '0;
                            if_ack_d   = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= 8'd0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            last_d_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            timeout_q  <= timeout_d;
`ifdef MEM_ARBITER_RR_EN
            last_d_q   <= last_d_d;
`endif
        end
    end

    // Memory strobe comes straight from the state so an asynchronous reset
    // drops it without waiting for a clock edge.
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = (state_q == BUSY_D) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign timeout   = timeout_q;

    assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter: a per-cycle vector table (inputs applied on
// the falling edge, outputs compared 1 time unit later) covering reset, a
// fetch, idle mem_ready and a store with changing inputs; then hand-written
// sequences for simultaneous requests, timeout and reset during an access.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic        timeout;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.n(32), .TMO(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall     (stall),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl  = {reset, if_req, d_req, d_we, mem_ready}
    // ectl = {mem_req, mem_we, if_ack, d_ack, stall, timeout}
    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] mrd;
        logic [5:0]  ectl;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [4:0] ctl, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] dwd,
                       input logic [31:0] mrd, input logic [5:0] ectl,
                       input logic [31:0] e_maddr, input logic [31:0] e_mwd,
                       input logic [31:0] e_ird, input logic [31:0] e_drd);
        vec_t v;
        v.ctl = ctl; v.ia = ia; v.da = da; v.dwd = dwd; v.mrd = mrd;
        v.ectl = ectl; v.e_maddr = e_maddr; v.e_mwd = e_mwd;
        v.e_ird = e_ird; v.e_drd = e_drd;
        tbl.push_back(v);
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    initial begin
        logic        last_d;
        logic        d_first;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] first_data;
        logic [31:0] second_data;

        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;

        //   ctl       ia         da         dwd           mrd           ectl       maddr      mwd           ird           drd
        add(5'b10000, 32'h0,     32'h0,     32'h0,        32'h0,        6'b000000, 32'h0,     32'h0,        32'h0,        32'h0);
        add(5'b10000, 32'h0,     32'h0,     32'h0,        32'h0,        6'b000000, 32'h0,     32'h0,        32'h0,        32'h0);
        add(5'b00000, 32'h0,     32'h0,     32'h0,        32'h0,        6'b000000, 32'h0,     32'h0,        32'h0,        32'h0);
        // fetch of 0x40, memory ready one cycle after mem_req
        add(5'b01000, 32'h40,    32'h0,     32'h0,        32'h0,        6'b000010, 32'h0,     32'h0,        32'h0,        32'h0);
        add(5'b01001, 32'h40,    32'h0,     32'h0,        32'h8C010004, 6'b100010, 32'h40,    32'h0,        32'h0,        32'h0);
        add(5'b01000, 32'h40,    32'h0,     32'h0,        32'h0,        6'b001000, 32'h40,    32'h0,        32'h8C010004, 32'h0);
        // mem_ready while idle must do nothing
        add(5'b00001, 32'h40,    32'h0,     32'h0,        32'h12345678, 6'b000000, 32'h40,    32'h0,        32'h8C010004, 32'h0);
        add(5'b00000, 32'h0,     32'h0,     32'h0,        32'h0,        6'b000000, 32'h40,    32'h0,        32'h8C010004, 32'h0);
        // store 0xDEADBEEF to 0x100, 3-cycle memory, inputs disturbed mid-access
        add(5'b00110, 32'h0,     32'h100,   32'hDEADBEEF, 32'h0,        6'b000010, 32'h40,    32'h0,        32'h8C010004, 32'h0);
        add(5'b00110, 32'h0,     32'h100,   32'hDEADBEEF, 32'h0,        6'b110010, 32'h100,   32'hDEADBEEF, 32'h8C010004, 32'h0);
        add(5'b00100, 32'h0,     32'h200,   32'h0,        32'h0,        6'b110010, 32'h100,   32'hDEADBEEF, 32'h8C010004, 32'h0);
        add(5'b00111, 32'h0,     32'h100,   32'hDEADBEEF, 32'hA5A5A5A5, 6'b110010, 32'h100,   32'hDEADBEEF, 32'h8C010004, 32'h0);
        add(5'b00110, 32'h0,     32'h100,   32'hDEADBEEF, 32'h0,        6'b000100, 32'h100,   32'hDEADBEEF, 32'h8C010004, 32'hA5A5A5A5);
        add(5'b00000, 32'h0,     32'h0,     32'h0,        32'h0,        6'b000000, 32'h100,   32'hDEADBEEF, 32'h8C010004, 32'hA5A5A5A5);

        for (int unsigned i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset     = tbl[i].ctl[4];
            if_req    = tbl[i].ctl[3];
            d_req     = tbl[i].ctl[2];
            d_we      = tbl[i].ctl[1];
            mem_ready = tbl[i].ctl[0];
            if_addr   = tbl[i].ia;
            d_addr    = tbl[i].da;
            d_wdata   = tbl[i].dwd;
            mem_rdata = tbl[i].mrd;
            #1;
            check1 ($sformatf("v%0d mem_req",   i), mem_req,   tbl[i].ectl[5]);
            check1 ($sformatf("v%0d mem_we",    i), mem_we,    tbl[i].ectl[4]);
            check1 ($sformatf("v%0d if_ack",    i), if_ack,    tbl[i].ectl[3]);
            check1 ($sformatf("v%0d d_ack",     i), d_ack,     tbl[i].ectl[2]);
            check1 ($sformatf("v%0d stall",     i), stall,     tbl[i].ectl[1]);
            check1 ($sformatf("v%0d timeout",   i), timeout,   tbl[i].ectl[0]);
            check32($sformatf("v%0d mem_addr",  i), mem_addr,  tbl[i].e_maddr);
            check32($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].e_mwd);
            check32($sformatf("v%0d if_rdata",  i), if_rdata,  tbl[i].e_ird);
            check32($sformatf("v%0d d_rdata",   i), d_rdata,   tbl[i].e_drd);
        end

        // Simultaneous requests: both served, order set by the arbitration policy.
        last_d = 1'b1; // the store above was the last access served
        for (int k = 0; k < 4; k++) begin
            ia = 32'h1000 + 32'(k * 4);
            da = 32'h2000 + 32'(k * 8);
            first_data  = 32'hF000_0000 + 32'(k);
            second_data = 32'hE000_0000 + 32'(k);
            d_first = RR ? ~last_d : 1'b1;

            @(negedge clk);
            if_req = 1'b1; if_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = da;
            d_wdata = '0; mem_ready = 1'b0;
            #1;
            check1("tie idle mem_req", mem_req, 1'b0);
            check1("tie idle stall", stall, 1'b1);

            @(negedge clk);
            mem_ready = 1'b1; mem_rdata = first_data;
            #1;
            check1 ("tie first mem_req", mem_req, 1'b1);
            check32("tie first mem_addr", mem_addr, d_first ? da : ia);
            check1 ("tie first mem_we", mem_we, 1'b0);

            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            check1("tie first if_ack", if_ack, ~d_first);
            check1("tie first d_ack", d_ack, d_first);
            check32("tie first rdata", d_first ? d_rdata : if_rdata, first_data);

            @(negedge clk);
            if (d_first) d_req = 1'b0; else if_req = 1'b0;
            mem_ready = 1'b1; mem_rdata = second_data;
            #1;
            check1 ("tie second mem_req", mem_req, 1'b1);
            check32("tie second mem_addr", mem_addr, d_first ? ia : da);

            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            check1("tie second if_ack", if_ack, d_first);
            check1("tie second d_ack", d_ack, ~d_first);
            check32("tie second rdata", d_first ? if_rdata : d_rdata, second_data);
            last_d = ~d_first;
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;

        // Timeout: memory never ready, TMO=16 busy cycles.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h80; mem_rdata = 32'hFFFFFFFF; mem_ready = 1'b0;
        #1;
        check1("to idle mem_req", mem_req, 1'b0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            #1;
            check1($sformatf("to busy%0d mem_req", c), mem_req, 1'b1);
            check1($sformatf("to busy%0d if_ack", c), if_ack, 1'b0);
            check1($sformatf("to busy%0d timeout", c), timeout, 1'b0);
        end
        @(negedge clk);
        #1;
        check1 ("to ack if_ack", if_ack, 1'b1);
        check32("to ack if_rdata", if_rdata, 32'h0);
        check1 ("to ack timeout", timeout, 1'b1);
        check1 ("to ack mem_req", mem_req, 1'b0);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check1("to after if_ack", if_ack, 1'b0);
        check1("to after timeout", timeout, 1'b1);

        // Normal load after a timeout; flag stays set.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h600D0001;
        #1;
        check1 ("post-to mem_req", mem_req, 1'b1);
        check32("post-to mem_addr", mem_addr, 32'h44);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check1 ("post-to d_ack", d_ack, 1'b1);
        check32("post-to d_rdata", d_rdata, 32'h600D0001);
        check1 ("post-to timeout", timeout, 1'b1);
        @(negedge clk);
        d_req = 1'b0;

        // Reset in the middle of a data access.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        #1;
        check1("rst idle mem_req", mem_req, 1'b0);
        @(negedge clk);
        #1;
        check1 ("rst busy mem_req", mem_req, 1'b1);
        check32("rst busy mem_addr", mem_addr, 32'h300);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check1 ("rst async mem_req", mem_req, 1'b0);
        check1 ("rst async mem_we", mem_we, 1'b0);
        check32("rst async mem_addr", mem_addr, 32'h0);
        check1 ("rst async timeout", timeout, 1'b0);
        check32("rst async d_rdata", d_rdata, 32'h0);
        check1 ("rst async d_ack", d_ack, 1'b0);
        @(negedge clk);
        #1;
        check1("rst held d_ack", d_ack, 1'b0);
        check1("rst held mem_req", mem_req, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check1("rst rel mem_req", mem_req, 1'b0);
        check1("rst rel stall", stall, 1'b1);
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        check1 ("rst regrant mem_req", mem_req, 1'b1);
        check32("rst regrant mem_addr", mem_addr, 32'h300);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check1 ("rst reissue d_ack", d_ack, 1'b1);
        check32("rst reissue d_rdata", d_rdata, 32'hCAFEF00D);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        check1("rst final d_ack", d_ack, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
